// File: rtl/spi_reg_master.sv
// SPI mode-0 register-access master: a header byte {rw, width, addr} then one data byte.
// Status is shifted in during the header; read data is shifted in during the data byte.
module spi_reg_master #(
  parameter int ADDR_W   = 3,
  parameter int REG_W    = 8,
  parameter int HALF_DIV = 2,
  parameter int GAP      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rw,
  input  logic [1:0]        width,
  input  logic [ADDR_W-1:0] addr,
  input  logic [REG_W-1:0]  wdata,
  output logic              busy,
  output logic              done,
  output logic [REG_W-1:0]  rdata,
  output logic [REG_W-1:0]  status,
  output logic              spi_clk,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int TMR_MAX = (HALF_DIV > GAP) ? HALF_DIV : GAP;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int BIT_W   = $clog2(REG_W);

  localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(HALF_DIV - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(REG_W - 1);

  generate
    if (REG_W < ADDR_W + 3) begin : g_bad_reg_w
      $error("spi_reg_master: REG_W must be at least ADDR_W+3");
    end
    if (HALF_DIV < 1) begin : g_bad_half_div
      $error("spi_reg_master: HALF_DIV must be at least 1");
    end
    if (GAP < 1) begin : g_bad_gap
      $error("spi_reg_master: GAP must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_HDR,
    S_GAP,
    S_DATA,
    S_CS_HOLD,
    S_CS_IDLE
  } state_t;

  // Header layout: rw at the MSB, width just below it, addr at the bottom, zeros between.
  logic [REG_W-1:0] hdr_d;

  genvar gi;
  generate
    for (gi = 0; gi < REG_W; gi++) begin : g_hdr
      if (gi == REG_W - 1) begin : g_rw
        assign hdr_d[gi] = rw;
      end else if (gi >= REG_W - 3) begin : g_width
        assign hdr_d[gi] = width[gi-(REG_W-3)];
      end else if (gi < ADDR_W) begin : g_addr
        assign hdr_d[gi] = addr[gi];
      end else begin : g_zero
        assign hdr_d[gi] = 1'b0;
      end
    end
  endgenerate

  state_t           state_q;
  logic [TMR_W-1:0] tmr_q;
  logic [BIT_W-1:0] bit_q;
  logic             sclk_q;
  logic             cs_n_q;
  logic             busy_q;
  logic             done_q;
  logic             rw_q;
  logic [REG_W-1:0] tx_q;
  logic [REG_W-1:0] sh_q;
  logic [REG_W-1:0] rx_q;
  logic [REG_W-1:0] hstat_q;
  logic [REG_W-1:0] rdata_q;
  logic [REG_W-1:0] status_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rw_q     <= 1'b0;
      tx_q     <= '0;
      sh_q     <= '0;
      rx_q     <= '0;
      hstat_q  <= '0;
      rdata_q  <= '0;
      status_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rw_q    <= rw;
            tx_q    <= rw ? wdata : '0;
            sh_q    <= hdr_d;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            tmr_q   <= '0;
            bit_q   <= '0;
            state_q <= S_CS_SETUP;
          end
        end

        S_CS_SETUP: begin
          if (tmr_q != HALF_LAST) begin
            tmr_q <= tmr_q + TMR_W'(1);
          end else begin
            tmr_q   <= '0;
            state_q <= S_HDR;
          end
        end

        // Shared bit engine: low half-period, rising edge samples MISO,
        // high half-period, falling edge advances MOSI or closes the byte.
        S_HDR, S_DATA: begin
          if (tmr_q != HALF_LAST) begin
            tmr_q <= tmr_q + TMR_W'(1);
          end else begin
            tmr_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
              rx_q   <= {rx_q[REG_W-2:0], spi_miso};
            end else begin
              sclk_q <= 1'b0;
              if (bit_q != BIT_LAST) begin
                bit_q <= bit_q + BIT_W'(1);
                sh_q  <= {sh_q[REG_W-2:0], 1'b0};
              end else begin
                bit_q <= '0;
                if (state_q == S_HDR) begin
                  hstat_q <= rx_q;
                  sh_q    <= tx_q;
                  state_q <= S_GAP;
                end else begin
                  sh_q    <= '0;
                  state_q <= S_CS_HOLD;
                end
              end
            end
          end
        end

        S_GAP: begin
          if (tmr_q != GAP_LAST) begin
            tmr_q <= tmr_q + TMR_W'(1);
          end else begin
            tmr_q   <= '0;
            state_q <= S_DATA;
          end
        end

        S_CS_HOLD: begin
          if (tmr_q != HALF_LAST) begin
            tmr_q <= tmr_q + TMR_W'(1);
          end else begin
            tmr_q    <= '0;
            cs_n_q   <= 1'b1;
            done_q   <= 1'b1;
            status_q <= hstat_q;
            if (!rw_q) begin
              rdata_q <= rx_q;
            end
            state_q <= S_CS_IDLE;
          end
        end

        S_CS_IDLE: begin
          if (tmr_q != HALF_LAST) begin
            tmr_q <= tmr_q + TMR_W'(1);
          end else begin
            tmr_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign status   = status_q;
  assign spi_clk  = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = sh_q[REG_W-1];

endmodule
